// File: rtl/rr_grant_scheduler.sv
// Round-robin owner selection for a 16-way decoded resource. Grants are held until
// release, withdrawal or the HOLD_MAX limit, with a forced idle turnaround between owners.
module rr_grant_scheduler #(
    parameter logic [7:0] HOLD_MAX = 8'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        done,
    output logic [15:0] grant,
    output logic [3:0]  grant_idx,
    output logic        grant_valid,
    output logic        timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t      state_r, state_s;
    logic [3:0]  ptr_r, ptr_s;
    logic [7:0]  hold_cnt_r, hold_cnt_s;
    logic [15:0] grant_r, grant_s;
    logic [3:0]  grant_idx_r, grant_idx_s;
    logic        grant_valid_r, grant_valid_s;
    logic        timeout_r, timeout_s;
    logic [4:0]  pick_s;
    logic        user_release_s;
    logic        limit_hit_s;

    // Returns {found, index} of the first set request at or above base, wrapping at 15.
    function automatic logic [4:0] rr_pick(input logic [15:0] req_v, input logic [3:0] base);
        logic [4:0] res;
        logic [3:0] cand;
        res = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            cand = base + i[3:0];
            if (req_v[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    // Next-state and next-output decode.
    always_comb begin
        state_s        = state_r;
        ptr_s          = ptr_r;
        hold_cnt_s     = hold_cnt_r;
        grant_s        = grant_r;
        grant_idx_s    = grant_idx_r;
        grant_valid_s  = grant_valid_r;
        timeout_s      = 1'b0;
        pick_s         = rr_pick(req, ptr_r);
        user_release_s = done || !req[grant_idx_r];
        limit_hit_s    = (HOLD_MAX != 8'd0) && (hold_cnt_r == HOLD_MAX);

        case (state_r)
            ST_IDLE: begin
                if (pick_s[4]) begin
                    state_s       = ST_GRANT;
                    grant_idx_s   = pick_s[3:0];
                    grant_s       = 16'h0001 << pick_s[3:0];
                    grant_valid_s = 1'b1;
                    hold_cnt_s    = 8'd1;
                end else begin
                    grant_idx_s   = 4'h0;
                    grant_s       = 16'h0000;
                    grant_valid_s = 1'b0;
                end
            end
            ST_GRANT: begin
                if (user_release_s || limit_hit_s) begin
                    state_s       = ST_RECOVER;
                    grant_s       = 16'h0000;
                    grant_idx_s   = 4'h0;
                    grant_valid_s = 1'b0;
                    hold_cnt_s    = 8'd0;
                    ptr_s         = grant_idx_r + 4'd1;
                    // Registered, so the pulse lines up with the first grant-free cycle.
                    timeout_s     = !user_release_s;
                end else begin
                    hold_cnt_s = (hold_cnt_r == 8'hFF) ? hold_cnt_r : hold_cnt_r + 8'd1;
                end
            end
            ST_RECOVER: begin
                state_s       = ST_IDLE;
                grant_s       = 16'h0000;
                grant_idx_s   = 4'h0;
                grant_valid_s = 1'b0;
            end
            default: begin
                state_s       = ST_IDLE;
                ptr_s         = 4'h0;
                hold_cnt_s    = 8'd0;
                grant_s       = 16'h0000;
                grant_idx_s   = 4'h0;
                grant_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            ptr_r         <= 4'h0;
            hold_cnt_r    <= 8'd0;
            grant_r       <= 16'h0000;
            grant_idx_r   <= 4'h0;
            grant_valid_r <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            ptr_r         <= ptr_s;
            hold_cnt_r    <= hold_cnt_s;
            grant_r       <= grant_s;
            grant_idx_r   <= grant_idx_s;
            grant_valid_r <= grant_valid_s;
            timeout_r     <= timeout_s;
        end
    end

    assign grant       = grant_r;
    assign grant_idx   = grant_idx_r;
    assign grant_valid = grant_valid_r;
    assign timeout     = timeout_r;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler with HOLD_MAX=5; a grant-order scoreboard is
// pushed ahead of each stimulus and popped whenever a new grant appears.
module tb_rr_grant_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic        grant_valid;
    logic        timeout;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  cur_exp = 4'h0;
    logic        prev_v = 1'b0;

    always #5 clk = ~clk;

    rr_grant_scheduler #(.HOLD_MAX(8'd5)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .done(done),
        .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag, input int budget);
        int n;
        n = 0;
        while (grant_valid !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(grant_valid), 32'd1);
    endtask

    // Scoreboard monitor: checks every new owner and the held grant vector.
    always @(negedge clk) begin
        logic [3:0] e;
        e = cur_exp;
        if (grant_valid === 1'b1 && prev_v !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected: observed grant_idx=%0d expected no grant", grant_idx);
            end else begin
                e = exp_q.pop_front();
                chk("sb_idx", 32'(grant_idx), 32'(e));
            end
        end
        if (grant_valid === 1'b1) begin
            chk("sb_grant", 32'(grant), 32'(16'h0001 << e));
        end else begin
            chk("idle_grant", 32'(grant), 32'd0);
        end
        cur_exp <= e;
        prev_v  <= grant_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req   = 16'h0000;
        done  = 1'b0;
        step();
        step();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_idx", 32'(grant_idx), 32'd0);
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            done = i[0];
            step();
            chk("idle_no_grant", 32'(grant_valid), 32'd0);
        end
        done = 1'b0;

        // Round robin: all requesting, release on each grant's 2nd cycle.
        req = 16'hFFFF;
        for (int n = 0; n < 17; n++) begin
            exp_q.push_back(4'(n % 16));
            wait_grant("rr_wait", 6);
            step();
            chk("rr_hold2", 32'(grant_valid), 32'd1);
            done = 1'b1;
            step();
            done = 1'b0;
            chk("rr_release", 32'(grant_valid), 32'd0);
            chk("rr_no_timeout", 32'(timeout), 32'd0);
        end

        // Single requester 4: 3-cycle hold, 2 idle cycles, re-grant.
        req = 16'h0010;
        exp_q.push_back(4'd4);
        wait_grant("single_wait", 6);
        step();
        chk("single_c2", 32'(grant_valid), 32'd1);
        step();
        chk("single_c3", 32'(grant_idx), 32'd4);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("single_drop", 32'(grant_valid), 32'd0);
        chk("single_no_to", 32'(timeout), 32'd0);
        exp_q.push_back(4'd4);
        step();
        chk("single_gap", 32'(grant_valid), 32'd0);
        step();
        chk("single_regrant", 32'(grant), 32'h0010);
        done = 1'b1;
        step();
        done = 1'b0;
        req = 16'h0000;
        step();
        step();

        // Withdrawal by owner 7, then ptr must be 8.
        req = 16'h0080;
        exp_q.push_back(4'd7);
        wait_grant("wd_wait", 4);
        step();
        chk("wd_c2", 32'(grant_idx), 32'd7);
        req = 16'h0000;
        step();
        chk("wd_drop", 32'(grant_valid), 32'd0);
        chk("wd_no_to", 32'(timeout), 32'd0);
        req = 16'h0181;
        exp_q.push_back(4'd8);
        wait_grant("ptr8_wait", 4);
        step();

        // Asynchronous reset mid-grant, between edges.
        rst_n = 1'b0;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_valid", 32'(grant_valid), 32'd0);
        chk("arst_timeout", 32'(timeout), 32'd0);
        req = 16'h8008;
        exp_q.push_back(4'd3);
        step();
        rst_n = 1'b1;
        wait_grant("arst_regrant", 4);
        done = 1'b1;
        step();
        done = 1'b0;
        req = 16'h8000;
        exp_q.push_back(4'd15);
        wait_grant("own15_wait", 4);
        done = 1'b1;
        step();
        done = 1'b0;
        req = 16'h0000;
        step();
        step();

        // Timeout: owner 0 then owner 15, each held exactly 5 cycles.
        req = 16'h8001;
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd15);
        wait_grant("to_wait0", 4);
        chk("to_owner0", 32'(grant_idx), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_hold0", 32'(grant_valid), 32'd1);
            chk("to_early0", 32'(timeout), 32'd0);
        end
        step();
        chk("to_drop0", 32'(grant_valid), 32'd0);
        chk("to_pulse0", 32'(timeout), 32'd1);
        step();
        chk("to_once0", 32'(timeout), 32'd0);
        chk("to_idle0", 32'(grant_valid), 32'd0);
        step();
        chk("to_next15", 32'(grant_idx), 32'd15);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("to_hold15", 32'(grant_valid), 32'd1);
        end
        step();
        chk("to_pulse15", 32'(timeout), 32'd1);

        // done and limit collide on the 5th cycle: no timeout.
        exp_q.push_back(4'd0);
        wait_grant("col_wait", 4);
        for (int i = 0; i < 4; i++) begin
            step();
        end
        chk("col_c5", 32'(grant_valid), 32'd1);
        done = 1'b1;
        step();
        done = 1'b0;
        chk("col_drop", 32'(grant_valid), 32'd0);
        chk("col_no_to", 32'(timeout), 32'd0);
        req = 16'h0000;
        step();
        chk("col_no_to2", 32'(timeout), 32'd0);
        step();
        step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
